// File: rtl/stopwatch_disp_mux.sv
// Scans four BCD digits onto a 4-digit common-anode 7-segment display; an/sseg/frame_tick lag q by one cycle.
// No backpressure: load is always accepted, held pending and applied to the display only at a frame boundary.
module stopwatch_disp_mux #(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_in,
  input  logic       load,
  input  logic       blank_en,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int RB = REFRESH_BITS;

  logic [RB-1:0]   q;
  logic [1:0]      sel;
  logic            last;
  logic [3:0][3:0] load_dat;
  logic [3:0][3:0] disp_dat;
  logic [3:0][3:0] pend_dat;
  logic [3:0]      disp_dp;
  logic [3:0]      pend_dp;
  logic            pend_vld;
  logic [3:0]      cur;
  logic [7:0]      seg_dat;
  logic            blank3;
  logic            blank2;
  logic            blank1;
  logic            slot_blank;
  logic [3:0]      an_nxt;
  logic [7:0]      sseg_nxt;

  assign sel      = q[RB-1:RB-2];
  assign last     = &q;
  assign load_dat = {d3, d2, d1, d0};
  assign cur      = disp_dat[sel];

  // Display registers only change on the last cycle of a frame so one frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= '0;
      disp_dat <= '0;
      disp_dp  <= '0;
      pend_dat <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
    end else begin
      q <= q + RB'(1);
      if (last) begin
        if (load) begin
          disp_dat <= load_dat;
          disp_dp  <= dp_in;
        end else if (pend_vld) begin
          disp_dat <= pend_dat;
          disp_dp  <= pend_dp;
        end
        pend_vld <= 1'b0;
      end else if (load) begin
        pend_dat <= load_dat;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    case (cur)
      4'd0:    seg_dat = 8'hC0;
      4'd1:    seg_dat = 8'hF9;
      4'd2:    seg_dat = 8'hA4;
      4'd3:    seg_dat = 8'hB0;
      4'd4:    seg_dat = 8'h99;
      4'd5:    seg_dat = 8'h92;
      4'd6:    seg_dat = 8'h82;
      4'd7:    seg_dat = 8'hF8;
      4'd8:    seg_dat = 8'h80;
      4'd9:    seg_dat = 8'h90;
      default: seg_dat = 8'hBF;
    endcase
  end

  // Blanking chains down from the most significant digit; a non-zero (or invalid) code breaks the chain.
  assign blank3 = blank_en && (disp_dat[3] == 4'd0);
  assign blank2 = blank3 && (disp_dat[2] == 4'd0);
  assign blank1 = blank2 && (disp_dat[1] == 4'd0);

  always_comb begin
    case (sel)
      2'd3:    slot_blank = blank3;
      2'd2:    slot_blank = blank2;
      2'd1:    slot_blank = blank1;
      default: slot_blank = 1'b0;
    endcase
  end

  always_comb begin
    an_nxt   = ~(4'b0001 << sel);
    sseg_nxt = {~disp_dp[sel], seg_dat[6:0]};
    if (slot_blank) begin
      an_nxt   = 4'hF;
      sseg_nxt = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= 4'hF;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      sseg       <= sseg_nxt;
      frame_tick <= last;
    end
  end

endmodule

// File: tb/tb_stopwatch_disp_mux.sv
// Bench for stopwatch_disp_mux at REFRESH_BITS=4 (16-cycle frame, 4-cycle slots).
// Expected outputs are queued before each clock edge; observed outputs are queued after it.
module tb_stopwatch_disp_mux;

  localparam int RB    = 4;
  localparam int FRAME = 1 << RB;
  localparam int SLOT  = FRAME / 4;

  typedef struct packed {
    logic [3:0] anv;
    logic [7:0] seg;
    logic       ft;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d3 = '0, d2 = '0, d1 = '0, d0 = '0;
  logic [3:0] dp_in = '0;
  logic       load = 1'b0;
  logic       blank_en = 1'b0;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  out_t sb[$];
  out_t obs[$];
  int   checks = 0;
  int   errors = 0;

  int         mq;
  logic [3:0] md [4];
  logic [3:0] pd [4];
  logic [3:0] mdp, pdp;
  logic       mpend;
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
  logic [3:0] an_slot [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  always #5 clk = ~clk;

  stopwatch_disp_mux #(.REFRESH_BITS(RB)) dut (
    .clk(clk), .rst(rst), .d3(d3), .d2(d2), .d1(d1), .d0(d0), .dp_in(dp_in),
    .load(load), .blank_en(blank_en), .an(an), .sseg(sseg), .frame_tick(frame_tick)
  );

  task automatic model_reset();
    mq = 0; mdp = '0; pdp = '0; mpend = 1'b0;
    for (int i = 0; i < 4; i++) begin md[i] = '0; pd[i] = '0; end
  endtask

  function automatic out_t model_out();
    out_t e;
    int   s;
    logic bl [4];
    s     = mq / SLOT;
    bl[3] = blank_en && (md[3] == 4'd0);
    bl[2] = bl[3] && (md[2] == 4'd0);
    bl[1] = bl[2] && (md[1] == 4'd0);
    bl[0] = 1'b0;
    e.ft  = (mq == FRAME - 1);
    if (bl[s]) begin
      e.anv = 4'hF;
      e.seg = 8'hFF;
    end else begin
      e.anv = an_slot[s];
      e.seg = {~mdp[s], seg_tab[md[s]][6:0]};
    end
    return e;
  endfunction

  task automatic tick();
    logic [3:0] ld [4];
    sb.push_back(model_out());
    ld[0] = d0; ld[1] = d1; ld[2] = d2; ld[3] = d3;
    if (mq == FRAME - 1) begin
      if (load) begin md = ld; mdp = dp_in; end
      else if (mpend) begin md = pd; mdp = pdp; end
      mpend = 1'b0;
    end else if (load) begin
      pd = ld; pdp = dp_in; mpend = 1'b1;
    end
    mq = (mq + 1) % FRAME;
    @(posedge clk);
    #1;
    obs.push_back('{anv: an, seg: sseg, ft: frame_tick});
  endtask

  task automatic run_to(input int t);
    while (mq != t) tick();
  endtask

  task automatic drive(input logic [3:0] a3, a2, a1, a0, input logic [3:0] dp);
    d3 = a3; d2 = a2; d1 = a1; d0 = a0; dp_in = dp; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    out_t e, o;
    int   ft_cnt = 0;
    #2 rst = 1'b0;
    #10;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %h want f", an); end
    checks++; if (sseg !== 8'hFF) begin errors++; $display("FAIL reset_sseg got %h want ff", sseg); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft got %b want 0", frame_tick); end
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) tick();
    for (int i = 0; i < 2 * FRAME; i++) begin
      e = sb.pop_front(); o = obs.pop_front();
      if (o.ft) ft_cnt++;
      checks++;
      if (o !== e) begin errors++; $display("FAIL scan[%0d] got %h/%h/%b want %h/%h/%b", i, o.anv, o.seg, o.ft, e.anv, e.seg, e.ft); end
      if (i == 0) begin
        checks++;
        if (o.anv !== 4'hE || o.seg !== 8'hC0) begin errors++; $display("FAIL first_edge got %h/%h want e/c0", o.anv, o.seg); end
      end
    end
    checks++; if (ft_cnt != 2) begin errors++; $display("FAIL ft_count got %0d want 2", ft_cnt); end
  endtask

  task automatic test_load_mid_frame();
    out_t e, o;
    logic [3:0][7:0] cst;
    cst = {8'hF9, 8'h24, 8'hB0, 8'h99};
    run_to(6);
    drive(4'd1, 4'd2, 4'd3, 4'd4, 4'b0100);
    run_to(0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL load_cur got %h/%h/%b want %h/%h/%b", o.anv, o.seg, o.ft, e.anv, e.seg, e.ft); end
    end
    for (int i = 0; i < FRAME; i++) tick();
    for (int i = 0; i < FRAME; i++) begin
      e = sb.pop_front(); o = obs.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL load_next[%0d] got %h/%h/%b want %h/%h/%b", i, o.anv, o.seg, o.ft, e.anv, e.seg, e.ft); end
      checks++;
      if (o.anv !== an_slot[i/SLOT] || o.seg !== cst[i/SLOT]) begin
        errors++; $display("FAIL load_const[%0d] got %h/%h want %h/%h", i, o.anv, o.seg, an_slot[i/SLOT], cst[i/SLOT]);
      end
    end
  endtask

  task automatic test_blank();
    out_t e, o;
    logic [3:0][3:0] dg [3];
    logic [3:0][7:0] cst [3];
    logic [3:0][3:0] anc [3];
    dg[0] = 16'h0007; cst[0] = {8'hFF, 8'hFF, 8'hFF, 8'hF8}; anc[0] = 16'hFFFE;
    dg[1] = 16'h0000; cst[1] = {8'hFF, 8'hFF, 8'hFF, 8'hC0}; anc[1] = 16'hFFFE;
    dg[2] = 16'h0500; cst[2] = {8'hFF, 8'h92, 8'hC0, 8'hC0}; anc[2] = 16'hFBDE;
    blank_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      run_to(2);
      drive(dg[r][3], dg[r][2], dg[r][1], dg[r][0], 4'b0000);
      run_to(0);
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL blank_cur got %h/%h/%b want %h/%h/%b", o.anv, o.seg, o.ft, e.anv, e.seg, e.ft); end
      end
      for (int i = 0; i < FRAME; i++) tick();
      for (int i = 0; i < FRAME; i++) begin
        e = sb.pop_front(); o = obs.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL blank[%0d][%0d] got %h/%h/%b want %h/%h/%b", r, i, o.anv, o.seg, o.ft, e.anv, e.seg, e.ft); end
        checks++;
        if (o.anv !== anc[r][i/SLOT] || o.seg !== cst[r][i/SLOT]) begin
          errors++; $display("FAIL blank_const[%0d][%0d] got %h/%h want %h/%h", r, i, o.anv, o.seg, anc[r][i/SLOT], cst[r][i/SLOT]);
        end
      end
    end
    blank_en = 1'b0;
  endtask

  task automatic test_invalid();
    out_t e, o;
    logic [3:0][7:0] cst;
    cst = {8'hF9, 8'hA4, 8'hBF, 8'hB0};
    run_to(4);
    drive(4'd1, 4'd2, 4'hC, 4'd3, 4'b0000);
    run_to(0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL inv_cur got %h/%h/%b want %h/%h/%b", o.anv, o.seg, o.ft, e.anv, e.seg, e.ft); end
    end
    for (int i = 0; i < FRAME; i++) tick();
    for (int i = 0; i < FRAME; i++) begin
      e = sb.pop_front(); o = obs.pop_front();
      checks++;
      if (o.anv !== an_slot[i/SLOT] || o.seg !== cst[i/SLOT] || o !== e) begin
        errors++; $display("FAIL invalid[%0d] got %h/%h want %h/%h", i, o.anv, o.seg, an_slot[i/SLOT], cst[i/SLOT]);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_t e, o;
    logic [3:0][7:0] cst;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        cst = {8'h90, 8'h80, 8'hF8, 8'h82};
        run_to(FRAME - 1);
        drive(4'd9, 4'd8, 4'd7, 4'd6, 4'b0000);
      end else begin
        cst = {8'hA4, 8'hA4, 8'hA4, 8'hA4};
        run_to(3);
        drive(4'd1, 4'd1, 4'd1, 4'd1, 4'b0000);
        run_to(9);
        drive(4'd2, 4'd2, 4'd2, 4'd2, 4'b0000);
        run_to(0);
      end
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_cur got %h/%h/%b want %h/%h/%b", o.anv, o.seg, o.ft, e.anv, e.seg, e.ft); end
      end
      for (int i = 0; i < FRAME; i++) tick();
      for (int i = 0; i < FRAME; i++) begin
        e = sb.pop_front(); o = obs.pop_front();
        checks++;
        if (o.anv !== an_slot[i/SLOT] || o.seg !== cst[i/SLOT] || o !== e) begin
          errors++; $display("FAIL b2b[%0d][%0d] got %h/%h want %h/%h", pass, i, o.anv, o.seg, an_slot[i/SLOT], cst[i/SLOT]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    out_t e, o;
    run_to(5);
    drive(4'd3, 4'd3, 4'd3, 4'd3, 4'hF);
    run_to(8);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL arst_pre got %h/%h/%b want %h/%h/%b", o.anv, o.seg, o.ft, e.anv, e.seg, e.ft); end
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL arst_an got %h want f", an); end
    checks++; if (sseg !== 8'hFF) begin errors++; $display("FAIL arst_sseg got %h want ff", sseg); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL arst_ft got %b want 0", frame_tick); end
    model_reset();
    #3 rst = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) tick();
    for (int i = 0; i < 2 * FRAME; i++) begin
      e = sb.pop_front(); o = obs.pop_front();
      checks++;
      if (o.anv !== an_slot[(i%FRAME)/SLOT] || o.seg !== 8'hC0 || o !== e) begin
        errors++; $display("FAIL arst_post[%0d] got %h/%h want %h/c0", i, o.anv, o.seg, an_slot[(i%FRAME)/SLOT]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_mid_frame();
    test_blank();
    test_invalid();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
